ghost_mode_scheduler: RTL

Global ghost-mode controller for the ghost AI. It sequences all four ghost behaviour units through the arcade scatter/chase phase schedule and overrides it with frightened mode when Pac-Man eats a power pellet. Every mode change that reverses ghost direction issues a one-cycle reverse request. Per-ghost target selection (chase target vs. scatter corner vs. random) consumes its `mode` output.

---
 rtl/ghost_pkg.sv | 30 +++
 rtl/ghost_mode_scheduler_phase_timer.sv | 50 +++++
 rtl/ghost_mode_scheduler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ghost_pkg.sv
// rtl/ghost_pkg.sv - shared types and default timing for the ghost mode scheduler
// Contents:
//   ghost_mode_t : SCATTER=0, CHASE=1, FRIGHT=2 (encoding 3 unused)
//   NUM_PHASES   : number of schedule phases (0..7, last one indefinite)
//   DEF_*        : default durations in game ticks (60 Hz frames)
//   phase_mode() : schedule mode of a phase index
package ghost_pkg;

    typedef enum logic [1:0] {
        SCATTER = 2'd0,
        CHASE   = 2'd1,
        FRIGHT  = 2'd2
    } ghost_mode_t;

    localparam int NUM_PHASES = 8;
    localparam int LAST_PHASE = NUM_PHASES - 1;

    localparam int DEF_SCATTER_LONG  = 420;
    localparam int DEF_SCATTER_SHORT = 300;
    localparam int DEF_CHASE_LEN     = 1200;
    localparam int DEF_FRIGHT_LEN    = 360;
    localparam int DEF_WARN_LEN      = 120;
    localparam int DEF_CNT_W         = 12;

    // Even phases scatter, odd phases chase.
    function automatic ghost_mode_t phase_mode(input logic [2:0] idx);
        return idx[0] ? CHASE : SCATTER;
    endfunction

endpackage

// File: rtl/ghost_mode_scheduler_phase_timer.sv
// rtl/ghost_mode_scheduler_phase_timer.sv - loadable tick-gated down-counter with expiry flag
// Ports:
//   clk, reset      : clock, asynchronous active-low reset (count <= RESET_VAL)
//   tick            : count enable strobe
//   hold            : freezes the counter even when tick is high
//   load, load_val  : synchronous load, higher priority than counting
//   count_next      : value the counter takes at the next edge
//   expire          : tick accepted while count == 1 (owner must reload)
module phase_timer
    import ghost_pkg::*;
#(
    parameter int               CNT_W     = DEF_CNT_W,
    parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             hold,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count_next,
    output logic             expire
);

    logic [CNT_W-1:0] count;
    logic             run;

    assign run    = tick && !hold;
    assign expire = run && (count == CNT_W'(1));

    // The counter never goes below 1 on its own; expiry is handled by the
    // owner reloading it in the same cycle.
    always_comb begin
        count_next = count;
        if (load) begin
            count_next = load_val;
        end else if (run && (count > CNT_W'(1))) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= RESET_VAL;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/ghost_mode_scheduler.sv
// rtl/ghost_mode_scheduler.sv - global scatter/chase/frightened mode sequencer for the ghost AI
// Ports:
//   clk          : system clock
//   reset        : asynchronous active-low reset
//   tick         : one-cycle game-frame strobe, all durations count these
//   restart      : synchronous level-start / death pulse, highest priority
//   powerPellet  : one-cycle pulse when a power pellet is eaten
//   mode         : ghost_mode_t, registered
//   phaseIdx     : current schedule phase 0..7, registered
//   frightWarn   : registered, high in FRIGHT while remaining ticks <= WARN_LEN
//   reverse      : registered one-cycle reverse-direction command
module ghost_mode_scheduler
    import ghost_pkg::*;
#(
    parameter int SCATTER_LONG  = DEF_SCATTER_LONG,
    parameter int SCATTER_SHORT = DEF_SCATTER_SHORT,
    parameter int CHASE_LEN     = DEF_CHASE_LEN,
    parameter int FRIGHT_LEN    = DEF_FRIGHT_LEN,
    parameter int WARN_LEN      = DEF_WARN_LEN,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        restart,
    input  logic        powerPellet,
    output ghost_mode_t mode,
    output logic [2:0]  phaseIdx,
    output logic        frightWarn,
    output logic        reverse
);

    typedef enum logic {
        NORMAL     = 1'b0,
        FRIGHTENED = 1'b1
    } fsm_t;

    fsm_t             state;
    fsm_t             state_n;
    logic [2:0]       phase_n;
    logic [2:0]       phase_inc;
    logic             reverse_n;
    logic             frightened;

    logic             p_load;
    logic [CNT_W-1:0] p_val;
    logic             p_hold;
    logic             p_expire;
    logic [CNT_W-1:0] phase_cnt_next_unused;

    logic             f_load;
    logic [CNT_W-1:0] f_val;
    logic             f_hold;
    logic             f_expire;
    logic [CNT_W-1:0] f_next;

    function automatic logic [CNT_W-1:0] phase_len(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd2: return CNT_W'(SCATTER_LONG);
            3'd4, 3'd6: return CNT_W'(SCATTER_SHORT);
            default:    return CNT_W'(CHASE_LEN);
        endcase
    endfunction

    assign frightened = (state == FRIGHTENED);
    assign phase_inc  = phaseIdx + 3'd1;

    // The schedule pauses while frightened; the last phase never expires.
    assign p_hold = frightened || (phaseIdx == 3'(LAST_PHASE));
    assign f_hold = !frightened;

    phase_timer #(
        .CNT_W     (CNT_W),
        .RESET_VAL (CNT_W'(SCATTER_LONG))
    ) u_phase_timer (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .hold       (p_hold),
        .load       (p_load),
        .load_val   (p_val),
        .count_next (phase_cnt_next_unused),
        .expire     (p_expire)
    );

    phase_timer #(
        .CNT_W     (CNT_W),
        .RESET_VAL ('0)
    ) u_fright_timer (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .hold       (f_hold),
        .load       (f_load),
        .load_val   (f_val),
        .count_next (f_next),
        .expire     (f_expire)
    );

    // Next-state decode. A pellet is applied after phase/fright expiry so it
    // wins a tie with fright expiry, and a coincident phase expiry still
    // advances the phase with a single reverse pulse.
    always_comb begin
        state_n   = state;
        phase_n   = phaseIdx;
        reverse_n = 1'b0;
        p_load    = 1'b0;
        p_val     = phase_len(phase_inc);
        f_load    = 1'b0;
        f_val     = CNT_W'(FRIGHT_LEN);
        if (restart) begin
            state_n = NORMAL;
            phase_n = 3'd0;
            p_load  = 1'b1;
            p_val   = CNT_W'(SCATTER_LONG);
            f_load  = 1'b1;
            f_val   = '0;
        end else begin
            if (p_expire) begin
                phase_n   = phase_inc;
                p_load    = 1'b1;
                reverse_n = 1'b1;
            end
            if (f_expire) begin
                state_n = NORMAL;
                f_load  = 1'b1;
                f_val   = '0;
            end
            if (powerPellet) begin
                state_n = FRIGHTENED;
                f_load  = 1'b1;
                f_val   = CNT_W'(FRIGHT_LEN);
                if (!frightened) begin
                    reverse_n = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= NORMAL;
            phaseIdx   <= 3'd0;
            mode       <= SCATTER;
            frightWarn <= 1'b0;
            reverse    <= 1'b0;
        end else begin
            state      <= state_n;
            phaseIdx   <= phase_n;
            mode       <= (state_n == FRIGHTENED) ? FRIGHT : phase_mode(phase_n);
            frightWarn <= (state_n == FRIGHTENED) && (f_next <= CNT_W'(WARN_LEN));
            reverse    <= reverse_n;
        end
    end

endmodule
